uart_tx_sched: RTL

Frame-level scheduler that shares the single UART transmitter between two requesters: the command-acknowledge path (requester 0) and the telemetry/status path (requester 1). It accepts a 1–3 byte frame from whichever requester wins round-robin arbitration and drives `trmt`/`tx_data` one byte at a time, pacing on `tx_done`. Bytes go out MSB-first, so a 3-byte frame is byte-compatible with the host-side 24-bit command format. Frames are atomic: bytes from the two requesters never interleave.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_tx_sched_rr_arb2.sv | 18 +
 rtl/uart_tx_sched.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit scheduler.
// The ABORT state exists only when UART_TX_SCHED_TIMEOUT_EN is defined.
package uart_pkg;

    localparam int unsigned NUM_TX_REQ = 2;
    localparam int unsigned FRM_BYTES  = 3;
    localparam int unsigned FRM_W      = 8 * FRM_BYTES;
    localparam int unsigned WD_W       = 16;

    typedef logic [1:0] frm_len_t;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE,
        ST_ABORT
    } tx_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } tx_state_e;
`endif

    // Byte to send when 'rem' bytes remain; the most significant byte goes first.
    function automatic logic [7:0] frm_byte(input logic [FRM_W-1:0] data, input frm_len_t rem);
        case (rem)
            2'd1:    frm_byte = data[7:0];
            2'd2:    frm_byte = data[15:8];
            2'd3:    frm_byte = data[23:16];
            default: frm_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter; the pointer is held by the caller.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    // A lone requester always wins; on a tie the pointer decides.
    always_comb begin
        gnt_idx = req[1] & (~req[0] | ptr);
        gnt     = 2'b00;
        if (|req) begin
            gnt = {gnt_idx, ~gnt_idx};
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between two frame requesters.
// Frames of 0-3 bytes go out MSB-first and are never interleaved.
// Optional tx_done watchdog and ABORT state: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned TO_CYC = 30000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_TX_REQ-1:0]            frm_vld,
    input  logic [NUM_TX_REQ-1:0][FRM_W-1:0] frm_data,
    input  logic [NUM_TX_REQ-1:0][1:0]       frm_len,
    output logic [NUM_TX_REQ-1:0]            frm_ack,
    output logic [NUM_TX_REQ-1:0]            frm_done,
    output logic                             busy,
    output logic                             trmt,
    output logic [7:0]                       tx_data,
    input  logic                             tx_done,
    output logic                             err
);

    tx_state_e              state_q, state_d;
    logic                   ptr_q, ptr_d;
    logic                   w_q, w_d;
    logic [FRM_W-1:0]       data_q, data_d;
    frm_len_t               rem_q, rem_d;
    logic                   tx_done_q;
    logic                   tx_rise;
    logic [NUM_TX_REQ-1:0]  ack_d;
    logic                   done_set;
    logic                   load_byte;
    logic [NUM_TX_REQ-1:0]  gnt;
    logic                   gnt_idx;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [WD_W-1:0]        wd_q;
    logic                   abort_set;
    logic                   err_q;
`endif

    rr_arb2 u_arb (
        .req     (frm_vld),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign tx_rise = tx_done & ~tx_done_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control. DONE is held until its frm_done pulse is out,
    // so a zero-length frame spends two cycles there.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        w_d       = w_q;
        data_d    = data_q;
        rem_d     = rem_q;
        ack_d     = '0;
        done_set  = 1'b0;
        load_byte = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        abort_set = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|frm_vld) begin
                    w_d    = gnt_idx;
                    ack_d  = gnt;
                    data_d = frm_data[gnt_idx];
                    rem_d  = frm_len[gnt_idx];
                    if (frm_len[gnt_idx] == 2'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_SEND;
                        load_byte = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_rise) begin
                    rem_d = rem_q - 2'd1;
                    if (rem_q == 2'd1) begin
                        state_d  = ST_DONE;
                        done_set = 1'b1;
                    end else begin
                        state_d   = ST_SEND;
                        load_byte = 1'b1;
                    end
                end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                else if (wd_q == WD_W'(TO_CYC - 1)) begin
                    state_d   = ST_ABORT;
                    done_set  = 1'b1;
                    abort_set = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (frm_done == '0) begin
                    done_set = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    ptr_d   = ~w_q;
                end
            end
`ifdef UART_TX_SCHED_TIMEOUT_EN
            ST_ABORT: begin
                state_d = ST_IDLE;
                ptr_d   = ~w_q;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= 1'b0;
            w_q       <= 1'b0;
            data_q    <= '0;
            rem_q     <= '0;
            tx_done_q <= 1'b0;
            frm_ack   <= '0;
            frm_done  <= '0;
            busy      <= 1'b0;
            trmt      <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            ptr_q     <= ptr_d;
            w_q       <= w_d;
            data_q    <= data_d;
            rem_q     <= rem_d;
            tx_done_q <= tx_done;
            frm_ack   <= ack_d;
            frm_done  <= done_set ? {w_q, ~w_q} : '0;
            busy      <= (state_d != ST_IDLE);
            trmt      <= (state_d == ST_SEND);
            if (load_byte) begin
                tx_data <= frm_byte(data_d, rem_d);
            end
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // Watchdog counts cycles spent waiting for tx_done; err is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= (state_q == ST_WAIT) ? wd_q + WD_W'(1) : '0;
            err_q <= err_q | abort_set;
        end
    end

    assign err = err_q;
`else
    logic unused_to;
    assign unused_to = ^(32'(TO_CYC));
    assign err       = 1'b0;
`endif

endmodule
